regfile_banked: RTL and testbench
=================================

# regfile_banked

Per-thread banked integer register file for the barrel RISC-V core, sitting in the decode stage directly upstream of the decode/execute pipeline register. It holds one 32-entry register bank per hardware thread, serves two combinational reads for the thread currently in decode, and takes one write per cycle from writeback for any thread. After reset, a sequential clear engine zeroes every entry before the file reports ready.

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits
- BITS_THREADS, 3, log2 of the thread count; the file holds 2^BITS_THREADS banks

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous and active-high
- ready_o  out  1  high once the clear sequence has completed
- tid_d_i  in  BITS_THREADS  thread ID of the instruction in decode
- rs1_d_i  in  5  first source register index
- rs2_d_i  in  5  second source register index
- rd1_d_o  out  DATA_WIDTH  value of rs1 in bank tid_d_i (combinational)
- rd2_d_o  out  DATA_WIDTH  value of rs2 in bank tid_d_i (combinational)
- we_w_i  in  1  writeback write enable
- tid_w_i  in  BITS_THREADS  writeback thread ID
- rd_w_i  in  5  writeback destination index
- wd_w_i  in  DATA_WIDTH  writeback data

## Operation
- Storage: N = 32·2^BITS_THREADS entries, addressed as {tid, reg}.
- FSM states are CLEAR and RUN.
  - rst at a posedge: next state CLEAR, clear counter = 0, ready_o = 0.
  - In CLEAR, each cycle writes 0 to entry[counter] and increments the counter. The cycle that clears entry N−1 moves the FSM to RUN and sets ready_o = 1.
  - RUN is terminal until the next rst.
- In CLEAR:
  - rd1_d_o and rd2_d_o are forced to 0.
  - we_w_i is ignored, and no write is queued.
- In RUN:
  - If we_w_i = 1 and rd_w_i ≠ 0, the write commits wd_w_i to entry {tid_w_i, rd_w_i} at the posedge.
  - Writes with rd_w_i = 0 are discarded.
- Reads:
  - Index 0 always returns 0 in every bank, whatever the storage contents.
  - rd1 and rd2 are independent. rs1 = rs2 returns the same value on both.
- Banks are fully isolated. A write to thread t never changes any read for thread u ≠ t.
- rst asserted in either state, including mid-clear, restarts the clear from entry 0.

## Timing
- Reset values: ready_o = 0; rd1_d_o = rd2_d_o = 0 until ready_o rises.
- Clear latency: ready_o goes high exactly N rising edges after the first edge with rst low. For BITS_THREADS = 3 this is 256 edges.
- Read latency is zero. Outputs follow tid_d_i/rs*_d_i combinationally and are captured by the downstream D/E register at the same edge.
- Write latency is one edge. The value is visible on reads in the cycle after the commit edge, or in the same cycle with bypass enabled (see Configuration).
- A simultaneous read and write to different {tid, reg} entries has no interaction.

## Configuration
- REGFILE_BYPASS_EN defined:
  - Bypass condition: RUN, we_w_i = 1, tid_w_i = tid_d_i, rd_w_i = rsX_d_i, and rsX_d_i ≠ 0.
  - When the condition holds, rdX_d_o returns wd_w_i in the same cycle (write-through).
- REGFILE_BYPASS_EN undefined: reads return the stored pre-write value during the write cycle. The scheduler guarantees thread spacing, so no same-thread read-after-write can occur.

## Test plan
- Reset, then hold rst low: ready_o = 0 for 255 edges and 1 at edge 256 (BITS_THREADS = 3). During clear, set all entries via backdoor-free writes and check reads = 0 afterwards.
- After ready: write 0xDEADBEEF to t2/x5 and 0x12345678 to t3/x5. Read t2/x5 → 0xDEADBEEF, t3/x5 → 0x12345678, t4/x5 → 0.
- Write 0xFFFFFFFF to t1/x0, then read t1 with rs1 = rs2 = 0 → both outputs 0.
- Same-cycle write t0/x7 = 0xA5A5A5A5 while reading t0/x7 (prior value 0):
  - With REGFILE_BYPASS_EN: read → 0xA5A5A5A5.
  - Without it: read → 0, then 0xA5A5A5A5 next cycle.
- Assert rst for one cycle at clear count 100: the clear restarts, and ready_o rises 256 edges after rst deasserts.
- In RUN, write t6/x31 = 0x1, then pulse rst: after the new clear completes, t6/x31 reads 0. A write issued during clear has no effect.

Source files
------------

// File: rtl/regfile_banked.sv
// rtl/regfile_banked.sv - per-thread banked register file with sequential clear after reset
// Optional same-cycle write-through bypass: define REGFILE_BYPASS_EN.
module regfile_banked #(
  parameter int DATA_WIDTH   = 32,
  parameter int BITS_THREADS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    ready_o,
  input  logic [BITS_THREADS-1:0] tid_d_i,
  input  logic [4:0]              rs1_d_i,
  input  logic [4:0]              rs2_d_i,
  output logic [DATA_WIDTH-1:0]   rd1_d_o,
  output logic [DATA_WIDTH-1:0]   rd2_d_o,
  input  logic                    we_w_i,
  input  logic [BITS_THREADS-1:0] tid_w_i,
  input  logic [4:0]              rd_w_i,
  input  logic [DATA_WIDTH-1:0]   wd_w_i
);

  localparam int ADDR_W = BITS_THREADS + 5;
  localparam int N      = 1 << ADDR_W;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     clr_cnt_q;
  logic [DATA_WIDTH-1:0] mem [N];

  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  running;

  // State register and clear counter; counter only advances while clearing
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == CLEAR) clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
    end
  end

  // Next state: leave CLEAR on the cycle that zeroes the last entry; RUN holds
  always_comb begin
    state_d = state_q;
    if (state_q == CLEAR && clr_cnt_q == ADDR_W'(N - 1)) state_d = RUN;
  end

  // Outputs of the FSM: ready flag and the single storage write port mux
  always_comb begin
    running   = (state_q == RUN);
    ready_o   = running;
    mem_we    = 1'b0;
    mem_waddr = clr_cnt_q;
    mem_wdata = '0;
    if (state_q == CLEAR) begin
      mem_we = 1'b1;
    end else begin
      mem_we    = we_w_i && (rd_w_i != 5'd0);
      mem_waddr = {tid_w_i, rd_w_i};
      mem_wdata = wd_w_i;
    end
  end

  // Storage write; suppressed on reset edges so a pending write cannot land
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Combinational read ports; x0 and the whole clear phase read as zero
  always_comb begin
    rd1_d_o = '0;
    rd2_d_o = '0;
    if (running) begin
      if (rs1_d_i != 5'd0) rd1_d_o = mem[{tid_d_i, rs1_d_i}];
      if (rs2_d_i != 5'd0) rd2_d_o = mem[{tid_d_i, rs2_d_i}];
`ifdef REGFILE_BYPASS_EN
      if (we_w_i && tid_w_i == tid_d_i && rs1_d_i != 5'd0 && rd_w_i == rs1_d_i) rd1_d_o = wd_w_i;
      if (we_w_i && tid_w_i == tid_d_i && rs2_d_i != 5'd0 && rd_w_i == rs2_d_i) rd2_d_o = wd_w_i;
`else
`endif
    end
  end

endmodule

// File: tb/tb_regfile_banked.sv
// tb/tb_regfile_banked.sv - self-checking bench for regfile_banked
module tb_regfile_banked;

  localparam int DW = 32;
  localparam int BT = 3;
  localparam int NT = 1 << BT;
  localparam int N  = 32 * NT;

  logic          clk = 1'b0;
  logic          rst;
  logic          ready_o;
  logic [BT-1:0] tid_d_i, tid_w_i;
  logic [4:0]    rs1_d_i, rs2_d_i, rd_w_i;
  logic [DW-1:0] rd1_d_o, rd2_d_o, wd_w_i;
  logic          we_w_i;

  int errors = 0;
  int checks = 0;

  regfile_banked #(.DATA_WIDTH(DW), .BITS_THREADS(BT)) dut (
    .clk(clk), .rst(rst), .ready_o(ready_o),
    .tid_d_i(tid_d_i), .rs1_d_i(rs1_d_i), .rs2_d_i(rs2_d_i),
    .rd1_d_o(rd1_d_o), .rd2_d_o(rd2_d_o),
    .we_w_i(we_w_i), .tid_w_i(tid_w_i), .rd_w_i(rd_w_i), .wd_w_i(wd_w_i)
  );

  always #5 clk = ~clk;

  // Behavioural model: per-thread banks, a ready flag and edges since reset
  logic [DW-1:0] m_bank [NT][32];
  bit            m_ready = 0;
  bit            m_valid = 0;
  int            m_edges = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1;
      m_ready = 0;
      m_edges = 0;
      for (int t = 0; t < NT; t++)
        for (int r = 0; r < 32; r++) m_bank[t][r] = '0;
    end else if (!m_ready) begin
      m_edges++;
      if (m_edges == N) m_ready = 1;
    end else if (we_w_i && rd_w_i != 0) begin
      m_bank[tid_w_i][rd_w_i] = wd_w_i;
    end
  end

  function automatic logic [DW-1:0] m_read(input logic [4:0] rs);
    if (!m_ready || rs == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we_w_i && tid_w_i == tid_d_i && rd_w_i == rs) return wd_w_i;
`endif
    return m_bank[tid_d_i][rs];
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous compare against the model on the falling edge
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_ready", {31'd0, ready_o}, {31'd0, m_ready});
      check("model_rd1", rd1_d_o, m_read(rs1_d_i));
      check("model_rd2", rd2_d_o, m_read(rs2_d_i));
    end
  end

  task automatic wr(input int t, input int r, input logic [DW-1:0] d);
    we_w_i = 1'b1; tid_w_i = BT'(t); rd_w_i = 5'(r); wd_w_i = d;
    @(posedge clk); #1;
    we_w_i = 1'b0;
  endtask

  task automatic rd_chk(input string name, input int t, input int r1, input int r2,
                        input logic [DW-1:0] e1, input logic [DW-1:0] e2);
    tid_d_i = BT'(t); rs1_d_i = 5'(r1); rs2_d_i = 5'(r2);
    #2;
    check({name, "_rd1"}, rd1_d_o, e1);
    check({name, "_rd2"}, rd2_d_o, e2);
  endtask

  // Count edges after rst release until ready rises, bounded
  task automatic wait_ready(input string name, input bit write_during);
    int n = 0;
    while (n < N + 40) begin
      if (write_during) begin
        we_w_i = 1'b1; tid_w_i = BT'(n % NT); rd_w_i = 5'(n % 32); wd_w_i = 32'hBAD0_0000 | n;
      end
      @(posedge clk); #1;
      n++;
      if (ready_o) break;
    end
    we_w_i = 1'b0;
    check(name, n, N);
  endtask

  initial begin
    rst = 1'b1; we_w_i = 0; tid_w_i = 0; rd_w_i = 0; wd_w_i = 0;
    tid_d_i = 0; rs1_d_i = 0; rs2_d_i = 0;
    repeat (2) @(posedge clk); #1;
    check("reset_ready", {31'd0, ready_o}, 32'd0);
    rs1_d_i = 5; rs2_d_i = 9; #1;
    check("reset_rd1", rd1_d_o, 32'd0);
    rst = 1'b0;

    wait_ready("clear_latency", 1'b1);
    rd_chk("after_clear_a", 0, 0, 1, 32'd0, 32'd0);
    rd_chk("after_clear_b", 3, 3, 31, 32'd0, 32'd0);

    wr(2, 5, 32'hDEADBEEF);
    wr(3, 5, 32'h12345678);
    rd_chk("t2x5", 2, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF);
    rd_chk("t3x5", 3, 5, 0, 32'h12345678, 32'd0);
    rd_chk("t4x5", 4, 5, 5, 32'd0, 32'd0);

    wr(1, 0, 32'hFFFFFFFF);
    rd_chk("t1x0", 1, 0, 0, 32'd0, 32'd0);

    // Same-cycle read and write of t0/x7
    tid_d_i = 0; rs1_d_i = 7; rs2_d_i = 7;
    we_w_i = 1; tid_w_i = 0; rd_w_i = 7; wd_w_i = 32'hA5A5A5A5;
    #2;
`ifdef REGFILE_BYPASS_EN
    check("raw_same_cycle", rd1_d_o, 32'hA5A5A5A5);
`else
    check("raw_same_cycle", rd1_d_o, 32'd0);
`endif
    @(posedge clk); #1; we_w_i = 0; #1;
    check("raw_next_cycle", rd2_d_o, 32'hA5A5A5A5);

    // Independent ports, different registers in the same bank
    wr(0, 8, 32'h0000_1111);
    rd_chk("two_regs", 0, 7, 8, 32'hA5A5A5A5, 32'h0000_1111);

    // Reset mid-clear at count 100
    @(posedge clk); #1; rst = 1;
    @(posedge clk); #1; rst = 0;
    repeat (100) begin @(posedge clk); #1; end
    check("midclear_not_ready", {31'd0, ready_o}, 32'd0);
    rst = 1;
    @(posedge clk); #1; rst = 0;
    wait_ready("restart_latency", 1'b0);

    // A RUN write is wiped by a later reset; writes during clear are dropped
    wr(6, 31, 32'h1);
    rd_chk("t6x31_set", 6, 31, 31, 32'h1, 32'h1);
    rst = 1;
    @(posedge clk); #1; rst = 0;
    wait_ready("reclear_latency", 1'b1);
    rd_chk("t6x31_cleared", 6, 31, 30, 32'd0, 32'd0);
    rd_chk("clear_write_dropped", 1, 1, 2, 32'd0, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
